// File: rtl/id_stage_if.sv
// Bundle between the IF/ID register, WB stage, hazard unit and ID/EX register
// on one side and the decode stage on the other. The decode stage takes the
// slave modport; the surrounding pipeline (or a bench) takes master.
interface id_stage_if #(
   parameter int DATA_W = 32
);
   logic [31:0]       instr_in;
   logic [DATA_W-1:0] pc_plus_four_in;
   logic [3:0]        status_bits_in;
   logic              hazard_in;
   logic              wb_en_in;
   logic [3:0]        wb_dest_in;
   logic [DATA_W-1:0] wb_value_in;

   logic              wb_en_out;
   logic              mem_r_en_out;
   logic              mem_w_en_out;
   logic              branch_taken_out;
   logic              do_update_sr_out;
   logic [3:0]        execute_command_out;
   logic [3:0]        wb_reg_dest_out;
   logic [DATA_W-1:0] pc_plus_four_out;
   logic [DATA_W-1:0] branch_immediate_out;
   logic [11:0]       instr_shifter_opperand_out;
   logic              instr_is_immediate_out;
   logic [DATA_W-1:0] val_rn_out;
   logic [DATA_W-1:0] val_rm_out;
   logic [3:0]        status_bits_out;
   logic [3:0]        src1_out;
   logic [3:0]        src2_out;
   logic              two_src_out;

   modport master (
      output instr_in, pc_plus_four_in, status_bits_in, hazard_in,
             wb_en_in, wb_dest_in, wb_value_in,
      input  wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out,
             do_update_sr_out, execute_command_out, wb_reg_dest_out,
             pc_plus_four_out, branch_immediate_out,
             instr_shifter_opperand_out, instr_is_immediate_out,
             val_rn_out, val_rm_out, status_bits_out, src1_out, src2_out,
             two_src_out
   );

   modport slave (
      input  instr_in, pc_plus_four_in, status_bits_in, hazard_in,
             wb_en_in, wb_dest_in, wb_value_in,
      output wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out,
             do_update_sr_out, execute_command_out, wb_reg_dest_out,
             pc_plus_four_out, branch_immediate_out,
             instr_shifter_opperand_out, instr_is_immediate_out,
             val_rn_out, val_rm_out, status_bits_out, src1_out, src2_out,
             two_src_out
   );
endinterface

// File: rtl/id_stage.sv
// Instruction-decode stage of the ARM-subset pipeline: register file R0..R14,
// control decoder, condition check and branch-immediate generation. Outputs
// are purely combinational; the downstream ID/EX register supplies the cycle.
// Optional macro ID_REGFILE_BYPASS_EN: forward the write-back value to a read
// of the same register in the same cycle.
module id_stage #(
   parameter int REG_COUNT = 15,
   parameter int DATA_W    = 32
) (
   input logic         clk,
   input logic         rst,
   id_stage_if.slave   bus
);

   typedef enum logic [1:0] {CLS_NONE, CLS_DP, CLS_MEM, CLS_BR} instr_class_t;

   logic [DATA_W-1:0] regs [REG_COUNT];

   instr_class_t cls;
   logic [3:0]   op;
   logic [3:0]   cmd;
   logic         dp_valid;
   logic         wb_raw, mr_raw, mw_raw, br_raw, sr_raw;
   logic         two_src;
   logic [3:0]   src1, src2;
   logic         cond_pass;
   logic         n_f, z_f, c_f, v_f;
   logic         go;
   logic [DATA_W-1:0] rn_val, rm_val;

   assign op = bus.instr_in[24:21];

   // Register file: async clear, write-back on rising edge, index 15 ignored
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      end else if (bus.wb_en_in && bus.wb_dest_in != 4'hF) begin
         regs[bus.wb_dest_in] <= bus.wb_value_in;
      end
   end

   // Condition field evaluated against NZCV
   always_comb begin
      {n_f, z_f, c_f, v_f} = bus.status_bits_in;
      cond_pass = 1'b0;
      case (bus.instr_in[31:28])
         4'b0000: cond_pass = z_f;
         4'b0001: cond_pass = ~z_f;
         4'b0010: cond_pass = c_f;
         4'b0011: cond_pass = ~c_f;
         4'b0100: cond_pass = n_f;
         4'b0101: cond_pass = ~n_f;
         4'b0110: cond_pass = v_f;
         4'b0111: cond_pass = ~v_f;
         4'b1000: cond_pass = c_f & ~z_f;
         4'b1001: cond_pass = ~c_f | z_f;
         4'b1010: cond_pass = (n_f == v_f);
         4'b1011: cond_pass = (n_f != v_f);
         4'b1100: cond_pass = ~z_f & (n_f == v_f);
         4'b1101: cond_pass = z_f | (n_f != v_f);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Instruction class, ALU command, raw enables and source selection
   always_comb begin
      cls      = CLS_NONE;
      cmd      = 4'b0000;
      dp_valid = 1'b1;
      wb_raw   = 1'b0;
      mr_raw   = 1'b0;
      mw_raw   = 1'b0;
      br_raw   = 1'b0;
      sr_raw   = 1'b0;
      two_src  = 1'b0;
      src1     = bus.instr_in[19:16];
      src2     = bus.instr_in[3:0];

      if (bus.instr_in[27:26] == 2'b00)       cls = CLS_DP;
      else if (bus.instr_in[27:26] == 2'b01)  cls = CLS_MEM;
      else if (bus.instr_in[27:25] == 3'b101) cls = CLS_BR;

      case (cls)
         CLS_DP: begin
            case (op)
               4'b1101: cmd = 4'b0001;
               4'b1111: cmd = 4'b1001;
               4'b0100: cmd = 4'b0010;
               4'b0101: cmd = 4'b0011;
               4'b0010: cmd = 4'b0100;
               4'b0110: cmd = 4'b0101;
               4'b0000: cmd = 4'b0110;
               4'b1100: cmd = 4'b0111;
               4'b0001: cmd = 4'b1000;
               4'b1010: cmd = 4'b0100;
               4'b1000: cmd = 4'b0110;
               default: dp_valid = 1'b0;
            endcase
            wb_raw  = dp_valid && op != 4'b1010 && op != 4'b1000;
            sr_raw  = dp_valid & bus.instr_in[20];
            // MOV/MVN register form reads only Rm, which travels on src2
            two_src = ~bus.instr_in[25];
         end
         CLS_MEM: begin
            cmd = 4'b0010;
            if (bus.instr_in[20]) begin
               wb_raw = 1'b1;
               mr_raw = 1'b1;
            end else begin
               mw_raw  = 1'b1;
               two_src = 1'b1;
               src2    = bus.instr_in[15:12];
            end
         end
         CLS_BR: br_raw = 1'b1;
         default: ;
      endcase
   end

   // Register reads; R15 returns PC+4
   always_comb begin
      rn_val = (src1 == 4'hF) ? bus.pc_plus_four_in : regs[src1];
      rm_val = (src2 == 4'hF) ? bus.pc_plus_four_in : regs[src2];
`ifdef ID_REGFILE_BYPASS_EN
      if (bus.wb_en_in && bus.wb_dest_in != 4'hF) begin
         if (bus.wb_dest_in == src1) rn_val = bus.wb_value_in;
         if (bus.wb_dest_in == src2) rm_val = bus.wb_value_in;
      end
`endif
   end

   assign go = cond_pass & ~bus.hazard_in;

   assign bus.wb_en_out                  = wb_raw & go;
   assign bus.mem_r_en_out               = mr_raw & go;
   assign bus.mem_w_en_out               = mw_raw & go;
   assign bus.branch_taken_out           = br_raw & go;
   assign bus.do_update_sr_out           = sr_raw & go;
   assign bus.execute_command_out        = cmd;
   assign bus.wb_reg_dest_out            = bus.instr_in[15:12];
   assign bus.pc_plus_four_out           = bus.pc_plus_four_in;
   assign bus.branch_immediate_out       = DATA_W'({{6{bus.instr_in[23]}}, bus.instr_in[23:0], 2'b00});
   assign bus.instr_shifter_opperand_out = bus.instr_in[11:0];
   assign bus.instr_is_immediate_out     = bus.instr_in[25];
   assign bus.val_rn_out                 = rn_val;
   assign bus.val_rm_out                 = rm_val;
   assign bus.status_bits_out            = bus.status_bits_in;
   assign bus.src1_out                   = src1;
   assign bus.src2_out                   = src2;
   assign bus.two_src_out                = two_src;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a table-driven decode model is checked against
// the DUT at every falling edge, plus hand-computed literal expectations.
module tb_id_stage;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   id_stage_if #(.DATA_W(32)) bus ();

   id_stage #(.REG_COUNT(15), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // model state: register contents and opcode table {valid, command}
   logic [31:0] mregs [15];
   logic [4:0]  dp_tab [16];

   initial begin
      dp_tab = '{5'h16, 5'h18, 5'h14, 5'h00, 5'h12, 5'h13, 5'h15, 5'h00,
                 5'h16, 5'h00, 5'h14, 5'h00, 5'h17, 5'h11, 5'h00, 5'h19};
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 15; i++) mregs[i] <= '0;
      end else if (bus.wb_en_in && bus.wb_dest_in != 4'd15) begin
         mregs[bus.wb_dest_in] <= bus.wb_value_in;
      end
   end

   function automatic logic [31:0] rd(input logic [3:0] idx);
      logic [31:0] r;
      r = (idx == 4'd15) ? bus.pc_plus_four_in : mregs[idx];
`ifdef ID_REGFILE_BYPASS_EN
      if (bus.wb_en_in && bus.wb_dest_in != 4'd15 && bus.wb_dest_in == idx) r = bus.wb_value_in;
`endif
      return r;
   endfunction

   function automatic logic [166:0] model();
      logic [31:0] ins;
      logic        n, z, c, v, hz, go;
      logic [15:0] ok;
      logic [3:0]  op, cmd, s1, s2;
      logic [4:0]  ent;
      logic        is_dp, is_mem, is_br, dp_ok, is_ldr, is_str, en_wb, sr, two;
      logic [31:0] bimm;
      ins = bus.instr_in;
      hz  = bus.hazard_in;
      {n, z, c, v} = bus.status_bits_in;
      ok = {1'b0, 1'b1, z | (n ^ v), ~z & ~(n ^ v), n ^ v, ~(n ^ v), ~c | z, c & ~z,
            ~v, v, ~n, n, ~c, c, ~z, z};
      go     = ok[ins[31:28]] & ~hz;
      is_dp  = ins[27:26] == 2'b00;
      is_mem = ins[27:26] == 2'b01;
      is_br  = ins[27:25] == 3'b101;
      op     = ins[24:21];
      ent    = dp_tab[op];
      dp_ok  = is_dp & ent[4];
      cmd    = dp_ok ? ent[3:0] : (is_mem ? 4'd2 : 4'd0);
      is_ldr = is_mem & ins[20];
      is_str = is_mem & ~ins[20];
      en_wb  = (dp_ok & (op != 4'd8) & (op != 4'd10)) | is_ldr;
      sr     = dp_ok & ins[20];
      s1     = ins[19:16];
      s2     = is_str ? ins[15:12] : ins[3:0];
      two    = is_str | (is_dp & ~ins[25]);
      bimm   = 32'(signed'(ins[23:0])) * 4;
      return {en_wb & go, is_ldr & go, is_str & go, is_br & go, sr & go, cmd,
              ins[15:12], bus.pc_plus_four_in, bimm, ins[11:0], ins[25],
              rd(s1), rd(s2), bus.status_bits_in, s1, s2, two};
   endfunction

   logic [166:0] act;
   assign act = {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.branch_taken_out,
                 bus.do_update_sr_out, bus.execute_command_out, bus.wb_reg_dest_out,
                 bus.pc_plus_four_out, bus.branch_immediate_out, bus.instr_shifter_opperand_out,
                 bus.instr_is_immediate_out, bus.val_rn_out, bus.val_rm_out,
                 bus.status_bits_out, bus.src1_out, bus.src2_out, bus.two_src_out};

   // compare process
   always @(negedge clk) begin
      logic [166:0] exp_v;
      exp_v = model();
      n_vec++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL model t=%0t instr=%h: got %h expected %h", $time, bus.instr_in, act, exp_v);
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, want);
      end
   endtask

   task automatic apply(input logic [31:0] ins, input logic [3:0] st, input logic hz);
      bus.instr_in       = ins;
      bus.status_bits_in = st;
      bus.hazard_in      = hz;
      @(negedge clk); #1;
   endtask

   task automatic wr(input logic [3:0] d, input logic [31:0] val);
      bus.wb_en_in    = 1'b1;
      bus.wb_dest_in  = d;
      bus.wb_value_in = val;
      @(posedge clk); #1;
      bus.wb_en_in = 1'b0;
   endtask

   logic [4:0] en5;

   initial begin
      bus.instr_in        = 32'hE083_1003;
      bus.pc_plus_four_in = 32'h0000_0100;
      bus.status_bits_in  = 4'b0000;
      bus.hazard_in       = 1'b0;
      bus.wb_en_in        = 1'b0;
      bus.wb_dest_in      = 4'd0;
      bus.wb_value_in     = '0;

      // reset state
      apply(32'hE083_1003, 4'b0000, 1'b0);
      chk("reset_rn", bus.val_rn_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;

      // write R3 then assert reset mid-cycle
      wr(4'd3, 32'hDEAD_BEEF);
      apply(32'hE083_1003, 4'b0000, 1'b0);
      chk("r3_written", bus.val_rn_out, 32'hDEAD_BEEF);
      rst = 1'b0;
      #1;
      chk("async_reset_rn", bus.val_rn_out, 32'h0);
      chk("async_reset_rm", bus.val_rm_out, 32'h0);
      @(posedge clk); #1;
      rst = 1'b1;
      apply(32'hE083_1003, 4'b0000, 1'b0);
      chk("post_reset_rn", bus.val_rn_out, 32'h0);

      // ADD R1,R2,R2
      wr(4'd2, 32'h0000_00AA);
      apply(32'hE082_1002, 4'b0000, 1'b0);
      chk("add_cmd", 32'(bus.execute_command_out), 32'h2);
      chk("add_wb_en", 32'(bus.wb_en_out), 32'h1);
      chk("add_rn", bus.val_rn_out, 32'hAA);
      chk("add_rm", bus.val_rm_out, 32'hAA);
      chk("add_two_src", 32'(bus.two_src_out), 32'h1);

      // STR R5,[R0]
      apply(32'hE580_5000, 4'b0000, 1'b0);
      chk("str_mem_w", 32'(bus.mem_w_en_out), 32'h1);
      chk("str_mem_r", 32'(bus.mem_r_en_out), 32'h0);
      chk("str_wb_en", 32'(bus.wb_en_out), 32'h0);
      chk("str_src2", 32'(bus.src2_out), 32'h5);
      chk("str_two_src", 32'(bus.two_src_out), 32'h1);

      // BNE backwards, Z=1 then Z=0
      apply(32'h1AFF_FFFE, 4'b0100, 1'b0);
      chk("bne_z1_taken", 32'(bus.branch_taken_out), 32'h0);
      chk("bne_imm", bus.branch_immediate_out, 32'hFFFF_FFF8);
      apply(32'h1AFF_FFFE, 4'b0000, 1'b0);
      chk("bne_z0_taken", 32'(bus.branch_taken_out), 32'h1);
      apply(32'hEA00_0010, 4'b0000, 1'b0);
      chk("b_fwd_imm", bus.branch_immediate_out, 32'h0000_0040);

      // hazard squashes all enables
      apply(32'hE092_1002, 4'b0000, 1'b1);
      en5 = {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.branch_taken_out, bus.do_update_sr_out};
      chk("hazard_adds_en", 32'(en5), 32'h0);
      chk("hazard_adds_cmd", 32'(bus.execute_command_out), 32'h2);
      apply(32'hE592_1004, 4'b0000, 1'b1);
      en5 = {bus.wb_en_out, bus.mem_r_en_out, bus.mem_w_en_out, bus.branch_taken_out, bus.do_update_sr_out};
      chk("hazard_ldr_en", 32'(en5), 32'h0);

      // write to index 15 ignored; R15 reads return PC+4
      wr(4'd15, 32'h5555_5555);
      apply(32'hE082_1002, 4'b0000, 1'b0);
      chk("w15_r2_kept", bus.val_rn_out, 32'hAA);
      bus.pc_plus_four_in = 32'h0000_1234;
      apply(32'hE08F_1002, 4'b0000, 1'b0);
      chk("pc_read", bus.val_rn_out, 32'h0000_1234);
      for (int i = 0; i < 15; i++) apply(32'hE080_1000 | (i << 16) | i, 4'b0000, 1'b0);

      // same-cycle write and read of R4
      wr(4'd4, 32'h0000_0077);
      bus.wb_en_in    = 1'b1;
      bus.wb_dest_in  = 4'd4;
      bus.wb_value_in = 32'h0000_1234;
      apply(32'hE084_1000, 4'b0000, 1'b0);
`ifdef ID_REGFILE_BYPASS_EN
      chk("same_cycle_rn", bus.val_rn_out, 32'h0000_1234);
`else
      chk("same_cycle_rn", bus.val_rn_out, 32'h0000_0077);
`endif
      @(posedge clk); #1;
      bus.wb_en_in = 1'b0;
      apply(32'hE084_1000, 4'b0000, 1'b0);
      chk("after_write_rn", bus.val_rn_out, 32'h0000_1234);

      // condition codes against every NZCV
      for (int cc = 0; cc < 16; cc++)
         for (int st = 0; st < 16; st++)
            apply((32'(cc) << 28) | 32'h0092_1002, 4'(st), 1'b0);
      apply(32'hC092_1002, 4'b0001, 1'b0);
      chk("gt_n0v1", 32'(bus.wb_en_out), 32'h0);
      apply(32'h8092_1002, 4'b0010, 1'b0);
      chk("hi_c1z0", 32'(bus.wb_en_out), 32'h1);

      // opcode sweep, both operand forms and S bit
      for (int op = 0; op < 16; op++)
         for (int f = 0; f < 4; f++)
            apply(32'hE002_1003 | (32'(f & 1) << 25) | (32'(op) << 21) | (32'(f >> 1) << 20),
                  4'b0000, 1'b0);
      apply(32'hE1B0_1003, 4'b0000, 1'b0);
      chk("movs_cmd", 32'(bus.execute_command_out), 32'h1);
      apply(32'hE150_0001, 4'b0000, 1'b0);
      chk("cmp_wb_en", 32'(bus.wb_en_out), 32'h0);
      chk("cmp_sr", 32'(bus.do_update_sr_out), 32'h1);
      apply(32'hE1C0_1002, 4'b0000, 1'b0);
      chk("undef_op_cmd", 32'(bus.execute_command_out), 32'h0);
      apply(32'hE592_1004, 4'b0000, 1'b0);
      chk("ldr_mem_r", 32'(bus.mem_r_en_out), 32'h1);
      apply(32'hEC00_0000, 4'b0000, 1'b0);
      apply(32'hE800_0000, 4'b0000, 1'b0);

      // random traffic with concurrent write-back
      for (int k = 0; k < 200; k++) begin
         bus.wb_en_in        = 1'($urandom_range(0, 1));
         bus.wb_dest_in      = 4'($urandom_range(0, 15));
         bus.wb_value_in     = $urandom;
         bus.pc_plus_four_in = $urandom;
         apply($urandom, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
         @(posedge clk); #1;
      end
      bus.wb_en_in = 1'b0;
      @(negedge clk); #1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage of the ARM-subset pipeline. It sits directly upstream of the ID/EX pipeline register and drives every one of that register's inputs.
- Contains the 15-entry general register file (R0..R14) with write-back port, the control decoder, the condition-code check and the branch-immediate generator.
- Exports source-register indices to the hazard unit and accepts a stall back from it.

Parameters:
- REG_COUNT, 15, number of physical registers (R0..R14); R15 is the PC and is not stored.
- DATA_W, 32, register and datapath width.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- instr_in  in  32  instruction from IF/ID register
- pc_plus_four_in  in  32  PC+4 from IF/ID register
- status_bits_in  in  4  current NZCV, bit order {N,Z,C,V}
- hazard_in  in  1  stall request from hazard unit
- wb_en_in  in  1  write-back enable from WB stage
- wb_dest_in  in  4  write-back register index
- wb_value_in  in  32  write-back data
- wb_en_out, mem_r_en_out, mem_w_en_out, branch_taken_out, do_update_sr_out  out  1 each  control to ID/EX
- execute_command_out  out  4  ALU command
- wb_reg_dest_out  out  4  Rd (instr[15:12])
- pc_plus_four_out  out  32  pass-through
- branch_immediate_out  out  32  sign-extended imm24 << 2
- instr_shifter_opperand_out  out  12  instr[11:0]
- instr_is_immediate_out  out  1  instr[25]
- val_rn_out, val_rm_out  out  32  register operands
- status_bits_out  out  4  pass-through of status_bits_in
- src1_out, src2_out  out  4 each  source indices for hazard unit
- two_src_out  out  1  src2 is actually read

Behaviour:
- Reset (rst=0, asynchronous): all R0..R14 cleared to 0 immediately. All outputs are combinational from inputs and register contents. There is no output register; latency is 0 cycles, and the ID/EX register provides the pipeline cycle.
- Register write:
  - On the rising edge, if rst=1, wb_en_in=1 and wb_dest_in!=15, then R[wb_dest_in] <= wb_value_in.
  - A write to index 15 is ignored.
  - Reset asserted in the same cycle as a write: reset wins, and the register stays 0.
- Register read:
  - src1 = instr[19:16] (Rn).
  - src2 = Rd (instr[15:12]) for STR, otherwise Rm (instr[3:0]).
  - Reading index 15 returns pc_plus_four_in.
- Instruction class decode:
  - instr[27:26]=00: data-processing.
  - instr[27:26]=01: memory. instr[20]=1 is LDR; instr[20]=0 is STR.
  - instr[27:25]=101: branch.
- Opcode decode, instr[24:21] -> execute_command:
  - MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110.
  - LDR/STR use 0010. Branch uses 0000.
  - An undefined opcode gives command 0000 and all enables 0.
- Enables:
  - wb_en: data-processing except CMP/TST, and LDR.
  - mem_r_en: LDR. mem_w_en: STR.
  - do_update_sr: instr[20] for data-processing; 0 for memory and branch.
  - branch_taken: branch class.
- two_src_out: 1 for STR, and for data-processing with instr[25]=0 other than MOV/MVN. MOV/MVN with a register operand set two_src only. src1 is considered unused for MOV/MVN and for branch.
- Condition check, instr[31:28] against NZCV:
  - EQ/NE on Z; CS/CC on C; MI/PL on N; VS/VC on V.
  - HI = C&~Z; LS = ~C|Z.
  - GE = N==V; LT = N!=V.
  - GT = ~Z&(N==V); LE = Z|(N!=V).
  - AL = 1; 1111 = 0.
- Squash: if the condition fails or hazard_in=1, force wb_en, mem_r_en, mem_w_en, branch_taken and do_update_sr to 0. All data outputs still reflect decode.
- branch_immediate: {{6{imm24[23]}}, imm24, 2'b00}.

Optional Feature:
- Macro ID_REGFILE_BYPASS_EN.
- Defined: write-through forwarding. When wb_en_in=1, wb_dest_in!=15 and wb_dest_in equals src1 (or src2), the corresponding val output returns wb_value_in in that same cycle.
- Undefined: reads return stored contents only. The new value is visible from the cycle after the write edge, and the hazard unit must stall one extra cycle.

Test Plan:
- Reset: assert rst=0 mid-operation after writes to R3 -> all registers read 0, including R3. val_rn for Rn=R3 reads 0 after release.
- Write R2=0x0000_00AA (wb_en=1, dest=2), then ADD R1,R2,R2 (0xE0821002) -> execute_command=0010, wb_en=1, val_rn=val_rm=0xAA, two_src=1.
- STR R5,[R0] (0xE5805000) -> mem_w_en=1, mem_r_en=0, wb_en=0, src2=5, two_src=1.
- BNE with imm24=0xFFFFFE and Z=1 -> branch_taken=0, branch_immediate=0xFFFF_FFF8. Same instruction with Z=0 -> branch_taken=1.
- Any valid instruction with hazard_in=1 -> all five enables 0. Write to dest=15 -> no register changes.
- With ID_REGFILE_BYPASS_EN: same-cycle write R4=0x1234 and read of Rn=R4 -> val_rn=0x1234. Without the macro -> old R4 value.
